// File: rtl/fetch_buffer_pkg.sv
// Shared types and helpers for the fetch-to-decode instruction buffer.
package fetch_buffer_pkg;

    localparam int unsigned FB_XLEN = 32;

    // One buffered instruction with its program counter.
    typedef struct packed {
        logic [FB_XLEN-1:0] pc;
        logic [FB_XLEN-1:0] instr;
    } fb_entry_t;

    // Per-lane valid control, used for debug views of issue lanes.
    typedef enum logic {
        LANE_IDLE  = 1'b0,
        LANE_VALID = 1'b1
    } lane_ctl_e;

    // Pointer width: index bits plus one wrap bit to tell full from empty.
    function automatic int unsigned fb_ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_buffer_lane_popcount.sv
// Counts set bits of a LANES-wide lane valid vector.
module lane_popcount #(
    parameter int unsigned LANES = 2
) (
    input  logic [LANES-1:0]             bits,
    output logic [$clog2(LANES+1)-1:0]   total
);

    localparam int unsigned TW = $clog2(LANES + 1);

    // Sum lane bits.
    always_comb begin
        total = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            total = total + TW'(bits[i]);
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// N-lane in-order instruction buffer between fetch and decode.
// Optional statistics outputs enabled by defining FETCH_BUFFER_STATS_EN.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int unsigned LANES = 2,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned XLEN  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [LANES-1:0]             in_valid,
    input  logic [LANES*XLEN-1:0]        in_pc,
    input  logic [LANES*XLEN-1:0]        in_instr,
    output logic                         in_ready,
    output logic [LANES-1:0]             out_valid,
    output logic [LANES*XLEN-1:0]        out_pc,
    output logic [LANES*XLEN-1:0]        out_instr,
    input  logic [$clog2(LANES+1)-1:0]   out_take,
`ifdef FETCH_BUFFER_STATS_EN
    output logic [$clog2(DEPTH+1)-1:0]   peak_count,
    output logic [31:0]                  stall_cycles,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = fb_ptr_w(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = $clog2(LANES + 1);

    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [LANES-1:0] valid_contig;
    logic [TW-1:0]   n_in;
    logic [TW-1:0]   n_out;
    logic [CW-1:0]   occ;

    // Keep only lanes below the first deasserted valid.
    always_comb begin
        valid_contig    = '0;
        valid_contig[0] = in_valid[0];
        for (int i = 1; i < int'(LANES); i++) begin
            valid_contig[i] = valid_contig[i-1] & in_valid[i];
        end
    end

    lane_popcount #(.LANES(LANES)) u_popcount (
        .bits  (valid_contig),
        .total (n_in)
    );

    // Occupancy, space check and clamped dequeue amount.
    always_comb begin
        occ      = CW'(tail - head);
        count    = occ;
        in_ready = (occ <= CW'(DEPTH - LANES));
        n_out    = (CW'(out_take) > occ) ? TW'(occ) : out_take;
    end

    // Present the oldest LANES entries starting at head.
    always_comb begin
        out_valid = '0;
        out_pc    = '0;
        out_instr = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            out_valid[i]                = (occ > CW'(i));
            out_pc[i*XLEN +: XLEN]      = pc_mem[IW'(head + PW'(i))];
            out_instr[i*XLEN +: XLEN]   = instr_mem[IW'(head + PW'(i))];
        end
    end

    // Ring pointers; reset and flush empty the buffer.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (in_ready) begin
                tail <= tail + PW'(n_in);
            end
            head <= head + PW'(n_out);
        end
    end

    // Entry storage, written at tail for accepted lanes; not reset.
    always_ff @(posedge clk) begin
        if (!reset && !flush && in_ready) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (TW'(i) < n_in) begin
                    pc_mem[IW'(tail + PW'(i))]    <= in_pc[i*XLEN +: XLEN];
                    instr_mem[IW'(tail + PW'(i))] <= in_instr[i*XLEN +: XLEN];
                end
            end
        end
    end

`ifdef FETCH_BUFFER_STATS_EN
    // High-water mark and saturating fetch-stall counter; survive flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            peak_count   <= '0;
            stall_cycles <= '0;
        end else begin
            if (occ > peak_count) begin
                peak_count <= occ;
            end
            if (in_valid[0] && !in_ready && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer (LANES=2, DEPTH=8), queue-based model.
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [1:0]  in_valid;
    logic [63:0] in_pc;
    logic [63:0] in_instr;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [63:0] out_pc;
    logic [63:0] out_instr;
    logic [1:0]  out_take;
    logic [3:0]  count;
`ifdef FETCH_BUFFER_STATS_EN
    logic [3:0]  peak_count;
    logic [31:0] stall_cycles;
    int          peak_m;
    int          stall_m;
`endif

    int          checks = 0;
    int          errors = 0;
    fb_entry_t   q[$];
    logic [31:0] next_pc;
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    fetch_buffer #(.LANES(2), .DEPTH(8), .XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_take     (out_take),
`ifdef FETCH_BUFFER_STATS_EN
        .peak_count   (peak_count),
        .stall_cycles (stall_cycles),
`endif
        .count        (count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare all visible state against the queue model.
    task automatic check_model();
        int sz;
        sz = q.size();
        chk("count", 64'(count), 64'(sz));
        chk("in_ready", 64'(in_ready), 64'((8 - sz) >= 2));
        chk("out_valid0", 64'(out_valid[0]), 64'(sz > 0));
        chk("out_valid1", 64'(out_valid[1]), 64'(sz > 1));
        for (int i = 0; i < 2; i++) begin
            if (i < sz) begin
                chk($sformatf("out_pc%0d", i), 64'(out_pc[i*32 +: 32]), 64'(q[i].pc));
                chk($sformatf("out_instr%0d", i), 64'(out_instr[i*32 +: 32]), 64'(q[i].instr));
            end
        end
`ifdef FETCH_BUFFER_STATS_EN
        chk("peak_count", 64'(peak_count), 64'(peak_m));
        chk("stall_cycles", 64'(stall_cycles), 64'(stall_m));
`endif
    endtask

    // One clock with given controls; model updated from pre-edge occupancy.
    task automatic cycle(input logic rst, input logic fl, input logic [1:0] v, input logic [1:0] take);
        fb_entry_t e0, e1;
        int sz, nin, nout;
        bit ready;
        e0.pc = next_pc;        e0.instr = $urandom;
        e1.pc = next_pc + 32'd4; e1.instr = $urandom;
        reset    = rst;
        flush    = fl;
        in_valid = v;
        out_take = take;
        in_pc    = {e1.pc, e0.pc};
        in_instr = {e1.instr, e0.instr};
        @(posedge clk);
        sz    = q.size();
        ready = (8 - sz) >= 2;
        nin   = v[0] ? (v[1] ? 2 : 1) : 0;
        nout  = (int'(take) < sz) ? int'(take) : sz;
`ifdef FETCH_BUFFER_STATS_EN
        if (rst) begin
            peak_m  = 0;
            stall_m = 0;
        end else begin
            if (sz > peak_m) peak_m = sz;
            if (v[0] && !ready) stall_m++;
        end
`endif
        if (rst || fl) begin
            q.delete();
            next_pc = next_pc + 32'd8;
        end else begin
            for (int i = 0; i < nout; i++) void'(q.pop_front());
            if (ready) begin
                if (nin > 0) q.push_back(e0);
                if (nin > 1) q.push_back(e1);
                next_pc = next_pc + 32'(4 * nin);
            end
        end
        #1;
        check_model();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = '0; out_take = '0;
        in_pc = '0; in_instr = '0;
        next_pc = 32'h0;
`ifdef FETCH_BUFFER_STATS_EN
        peak_m = 0; stall_m = 0;
`endif
        cycle(1'b1, 1'b0, 2'b00, 2'd0);
        cycle(1'b1, 1'b0, 2'b00, 2'd0);
        next_pc = 32'h0;
        cycle(1'b0, 1'b0, 2'b00, 2'd0);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_ready", 64'(in_ready), 64'd1);
        chk("reset_valid", 64'(out_valid), 64'd0);

        // First 2-lane enqueue with pc 0x0/0x4.
        cycle(1'b0, 1'b0, 2'b11, 2'd0);
        chk("enq_pc0", 64'(out_pc[31:0]), 64'h0);
        chk("enq_pc1", 64'(out_pc[63:32]), 64'h4);
        chk("enq_valid", 64'(out_valid), 64'h3);

        // Fill to full, then a refused fifth enqueue.
        repeat (3) cycle(1'b0, 1'b0, 2'b11, 2'd0);
        chk("full_count", 64'(count), 64'd8);
        chk("full_ready", 64'(in_ready), 64'd0);
        cycle(1'b0, 1'b0, 2'b11, 2'd0);
        chk("drop_count", 64'(count), 64'd8);

        // Full with simultaneous dequeue 2 and enqueue attempt.
        cycle(1'b0, 1'b0, 2'b11, 2'd2);
        chk("full_deq_count", 64'(count), 64'd6);
        chk("full_deq_pc", 64'(out_pc[31:0]), 64'h8);

        repeat (3) cycle(1'b0, 1'b0, 2'b00, 2'd2);
        chk("drained", 64'(count), 64'd0);

        // Steady 2-in/2-out stream across the index wrap.
        exp_pc = next_pc;
        cycle(1'b0, 1'b0, 2'b11, 2'd0);
        for (int k = 0; k < 10; k++) begin
            chk("wrap_pc0", 64'(out_pc[31:0]), 64'(exp_pc));
            chk("wrap_pc1", 64'(out_pc[63:32]), 64'(exp_pc + 32'd4));
            cycle(1'b0, 1'b0, 2'b11, 2'd2);
            exp_pc = exp_pc + 32'd8;
        end
        chk("wrap_pc_end", 64'(out_pc[31:0]), 64'(exp_pc));
        cycle(1'b0, 1'b0, 2'b00, 2'd2);

        // Flush at count 5 with concurrent enqueue and dequeue.
        cycle(1'b0, 1'b0, 2'b11, 2'd0);
        cycle(1'b0, 1'b0, 2'b11, 2'd0);
        cycle(1'b0, 1'b0, 2'b01, 2'd0);
        chk("pre_flush_count", 64'(count), 64'd5);
        cycle(1'b0, 1'b1, 2'b11, 2'd1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        cycle(1'b0, 1'b0, 2'b00, 2'd1);
        chk("empty_take_count", 64'(count), 64'd0);
        exp_pc = next_pc;
        cycle(1'b0, 1'b0, 2'b01, 2'd0);
        chk("post_flush_pc", 64'(out_pc[31:0]), 64'(exp_pc));

        // Randomized traffic, including non-contiguous valids.
        for (int k = 0; k < 400; k++) begin
            logic r, f;
            r = ($urandom_range(0, 99) == 0);
            f = ($urandom_range(0, 24) == 0);
            cycle(r, f, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
